jtkunio_obj_draw: RTL and testbench

//  Sprite line drawer in the Kunio video path; consumer of the SDRAM object ROM port (obj_addr/obj_cs/obj_data/obj_ok).
//  The object scanner hands it one 16-pixel sprite row at a time. It fetches two 32-bit words, applies h-flip and

---
 rtl/jtkunio_obj_draw_pkg.sv | 25 ++
 rtl/jtkunio_obj_draw_if.sv | 30 +++
 rtl/jtkunio_obj_draw.sv | 170 +++++++++++++++++
 tb/tb_jtkunio_obj_draw.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/jtkunio_obj_draw_pkg.sv
// Shared definitions for the Kunio sprite line drawer.
//  - default widths for the object ROM port and the line buffer
//  - drawer state encoding
//  - nibble picker used to apply horizontal flip to a fetched ROM word
package jtkunio_obj_draw_pkg;

  localparam int unsigned OBJ_CODEW = 13;
  localparam int unsigned OBJ_AW    = OBJ_CODEW + 4 + 1;
  localparam int unsigned OBJ_BUFW  = 9;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDraw
  } state_e;

  // Nibble n is the n-th pixel of an unflipped word; flipping reads 7-n instead.
  function automatic logic [3:0] pick_nibble(input logic [31:0] word, input logic [2:0] n,
                                             input logic flip);
    logic [2:0] idx;
    idx = flip ? ~n : n;
    return word[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/jtkunio_obj_draw_if.sv
// Object ROM request port between the sprite drawer and the SDRAM arbiter.
//  obj_addr  word address {code, vsub, half}
//  obj_cs    request, held until the data is accepted
//  obj_data  32-bit ROM word, 8 pixels of 4 bits
//  obj_ok    data valid for the current obj_addr
// master: the drawer; slave: the ROM side.
interface jtkunio_obj_draw_if #(
  parameter int unsigned AW = 18
) ();

  logic [AW-1:0] obj_addr;
  logic          obj_cs;
  logic [31:0]   obj_data;
  logic          obj_ok;

  modport master (
    output obj_addr,
    output obj_cs,
    input  obj_data,
    input  obj_ok
  );

  modport slave (
    input  obj_addr,
    input  obj_cs,
    output obj_data,
    output obj_ok
  );

endinterface

// File: rtl/jtkunio_obj_draw.sv
// Sprite line drawer. Takes one 16-pixel sprite row per draw pulse, fetches the two
// 32-bit ROM words holding it, and writes non-transparent {pal, pixel} entries into
// the object line buffer, one pixel per cen.
//  clk, rst      video clock, synchronous active-high reset
//  cen           pixel-write enable; only the drawing phase advances on it
//  draw          start pulse, taken only while busy is low
//  code, vsub    sprite tile code and row within the sprite
//  xpos          leftmost pixel x (buffer addresses wrap)
//  hflip, pal    horizontal mirror and palette select
//  busy          high from an accepted draw until the row is finished
//  rom           object ROM request port (master side)
//  buf_addr/din/we  line-buffer write port
module jtkunio_obj_draw
  import jtkunio_obj_draw_pkg::*;
#(
  parameter int unsigned AW    = OBJ_AW,
  parameter int unsigned CODEW = OBJ_CODEW,
  parameter int unsigned BUFW  = OBJ_BUFW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cen,
  input  logic             draw,
  input  logic [CODEW-1:0] code,
  input  logic [3:0]       vsub,
  input  logic [BUFW-1:0]  xpos,
  input  logic             hflip,
  input  logic [3:0]       pal,
  output logic             busy,
  jtkunio_obj_draw_if.master rom,
  output logic [BUFW-1:0]  buf_addr,
  output logic [7:0]       buf_din,
  output logic             buf_we
);

  state_e           state_q, state_d;
  logic             busy_q, busy_d;
  logic [CODEW-1:0] code_q, code_d;
  logic [3:0]       vsub_q, vsub_d;
  logic [BUFW-1:0]  xpos_q, xpos_d;
  logic             hflip_q, hflip_d;
  logic [3:0]       pal_q, pal_d;
  logic             half_q, half_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      data_q, data_d;
  logic             settle_q, settle_d;
  logic             cs_q, cs_d;
  logic [AW-1:0]    addr_q, addr_d;
  logic [BUFW-1:0]  baddr_q, baddr_d;
  logic [7:0]       din_q, din_d;
  logic             we_q, we_d;
  logic [3:0]       pix;

  assign busy         = busy_q;
  assign rom.obj_cs   = cs_q;
  assign rom.obj_addr = addr_q;
  assign buf_addr     = baddr_q;
  assign buf_din      = din_q;
  assign buf_we       = we_q;

  always_comb begin
    state_d  = state_q;
    busy_d   = busy_q;
    code_d   = code_q;
    vsub_d   = vsub_q;
    xpos_d   = xpos_q;
    hflip_d  = hflip_q;
    pal_d    = pal_q;
    half_d   = half_q;
    cnt_d    = cnt_q;
    data_d   = data_q;
    settle_d = settle_q;
    cs_d     = cs_q;
    addr_d   = addr_q;
    baddr_d  = baddr_q;
    din_d    = din_q;
    we_d     = 1'b0;
    pix      = 4'd0;
    unique case (state_q)
      StIdle: begin
        // busy lingers one edge past the last pixel, so a draw is never taken then
        busy_d = 1'b0;
        if (draw && !busy_q) begin
          code_d   = code;
          vsub_d   = vsub;
          xpos_d   = xpos;
          hflip_d  = hflip;
          pal_d    = pal;
          half_d   = hflip;
          cnt_d    = 4'd0;
          busy_d   = 1'b1;
          cs_d     = 1'b1;
          addr_d   = {code, vsub, hflip};
          settle_d = 1'b1;
          state_d  = StReq;
        end
      end
      StReq: begin
        // obj_ok may still refer to the previous address during the first cycle
        if (settle_q) begin
          settle_d = 1'b0;
        end else if (rom.obj_ok) begin
          data_d  = rom.obj_data;
          cs_d    = 1'b0;
          state_d = StDraw;
        end
      end
      StDraw: begin
        if (cen) begin
          pix     = pick_nibble(data_q, cnt_q[2:0], hflip_q);
          baddr_d = xpos_q + BUFW'(cnt_q);
          din_d   = {pal_q, pix};
          we_d    = (pix != 4'd0);
          cnt_d   = cnt_q + 4'd1;
          if (cnt_q[2:0] == 3'd7) begin
            if (cnt_q[3]) begin
              state_d = StIdle;
            end else begin
              half_d   = ~half_q;
              addr_d   = {code_q, vsub_q, ~half_q};
              cs_d     = 1'b1;
              settle_d = 1'b1;
              state_d  = StReq;
            end
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      busy_q   <= 1'b0;
      code_q   <= '0;
      vsub_q   <= '0;
      xpos_q   <= '0;
      hflip_q  <= 1'b0;
      pal_q    <= '0;
      half_q   <= 1'b0;
      cnt_q    <= '0;
      data_q   <= '0;
      settle_q <= 1'b0;
      cs_q     <= 1'b0;
      addr_q   <= '0;
      baddr_q  <= '0;
      din_q    <= '0;
      we_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      busy_q   <= busy_d;
      code_q   <= code_d;
      vsub_q   <= vsub_d;
      xpos_q   <= xpos_d;
      hflip_q  <= hflip_d;
      pal_q    <= pal_d;
      half_q   <= half_d;
      cnt_q    <= cnt_d;
      data_q   <= data_d;
      settle_q <= settle_d;
      cs_q     <= cs_d;
      addr_q   <= addr_d;
      baddr_q  <= baddr_d;
      din_q    <= din_d;
      we_q     <= we_d;
    end
  end

endmodule

// File: tb/tb_jtkunio_obj_draw.sv
// Self-checking bench for jtkunio_obj_draw: a ROM responder with random latency (or
// obj_ok stuck high with one-cycle-stale data), a scoreboard of expected line-buffer
// writes and ROM addresses built from a row-level model, and a monitor that pops and
// compares whenever the drawer writes or raises a request.
module tb_jtkunio_obj_draw;

  logic        clk = 1'b0;
  logic        rst;
  logic        cen;
  logic        draw;
  logic [12:0] code;
  logic [3:0]  vsub;
  logic [8:0]  xpos;
  logic        hflip;
  logic [3:0]  pal;
  logic        busy;
  logic [8:0]  buf_addr;
  logic [7:0]  buf_din;
  logic        buf_we;

  int checks = 0;
  int errors = 0;

  logic [16:0] exp_w[$];   // {addr[8:0], din[7:0]}
  logic [17:0] exp_a[$];
  logic [31:0] rom_ovr[logic [17:0]];
  bit          stuck_ok = 1'b0;

  jtkunio_obj_draw_if #(.AW(18)) rom_if ();

  jtkunio_obj_draw dut (
    .clk      (clk),
    .rst      (rst),
    .cen      (cen),
    .draw     (draw),
    .code     (code),
    .vsub     (vsub),
    .xpos     (xpos),
    .hflip    (hflip),
    .pal      (pal),
    .busy     (busy),
    .rom      (rom_if),
    .buf_addr (buf_addr),
    .buf_din  (buf_din),
    .buf_we   (buf_we)
  );

  initial forever #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ROM contents: a hash of the address with roughly a quarter of nibbles zeroed.
  function automatic logic [31:0] rom_word(input logic [17:0] a);
    logic [31:0] h, m;
    if (rom_ovr.exists(a)) return rom_ovr[a];
    h = {14'd0, a} * 32'h9E3779B1;
    h = h ^ (h >> 15);
    h = h * 32'h85EBCA6B;
    h = h ^ (h >> 13);
    m = h * 32'hC2B2AE35;
    for (int i = 0; i < 8; i++) if (m[i*4 +: 2] == 2'd0) h[i*4 +: 4] = 4'd0;
    return h;
  endfunction

  // Row model: the unflipped row is 16 pixels, left half in word half=0; mirroring
  // reverses the whole row and the word holding the left edge is fetched first.
  task automatic push_expected(input logic [12:0] c, input logic [3:0] v, input logic [8:0] x,
                               input logic hf, input logic [3:0] p);
    logic [3:0]  row[16];
    logic [31:0] w0, w1;
    logic [3:0]  px;
    logic [8:0]  ad;
    w0 = rom_word({c, v, 1'b0});
    w1 = rom_word({c, v, 1'b1});
    for (int k = 0; k < 8; k++) begin
      row[k]     = w0[k*4 +: 4];
      row[k + 8] = w1[k*4 +: 4];
    end
    exp_a.push_back({c, v, hf});
    exp_a.push_back({c, v, ~hf});
    for (int k = 0; k < 16; k++) begin
      px = hf ? row[15 - k] : row[k];
      ad = x + 9'(k);
      if (px != 4'd0) exp_w.push_back({ad, p, px});
    end
  endtask

  task automatic cen_gen();
    forever begin
      @(negedge clk);
      cen = ($urandom_range(0, 2) != 0);
    end
  endtask

  // Data follows the address one cycle late; obj_ok is only raised on stable data
  // unless stuck_ok forces it high all the time.
  task automatic rom_model();
    logic [17:0] last_addr = '0;
    int          wait_cnt = 0;
    bit          same;
    forever begin
      @(negedge clk);
      same = (rom_if.obj_addr == last_addr);
      rom_if.obj_data = rom_word(last_addr);
      last_addr = rom_if.obj_addr;
      if (stuck_ok) begin
        rom_if.obj_ok = 1'b1;
      end else if (rom_if.obj_cs && same) begin
        if (wait_cnt != 0) begin
          wait_cnt--;
          rom_if.obj_ok = 1'b0;
        end else begin
          rom_if.obj_ok = ($urandom_range(0, 3) != 0);
        end
      end else begin
        rom_if.obj_ok = 1'b0;
        wait_cnt = $urandom_range(0, 3);
      end
    end
  endtask

  task automatic monitor();
    logic        prev_cs = 1'b0;
    logic [16:0] e;
    logic [17:0] ea;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_cs = 1'b0;
      end else begin
        if (buf_we) begin
          if (exp_w.size() == 0) begin
            chk("unexpected_write", 64'({buf_addr, buf_din}), 64'h1_FFFF_FFFF);
          end else begin
            e = exp_w.pop_front();
            chk("buf_write", 64'({buf_addr, buf_din}), 64'(e));
          end
        end
        if (rom_if.obj_cs && !prev_cs) begin
          if (exp_a.size() == 0) begin
            chk("unexpected_req", 64'(rom_if.obj_addr), 64'h1_FFFF_FFFF);
          end else begin
            ea = exp_a.pop_front();
            chk("obj_addr", 64'(rom_if.obj_addr), 64'(ea));
          end
        end
        prev_cs = rom_if.obj_cs;
      end
    end
  endtask

  task automatic wait_idle(input int limit);
    int n = 0;
    while (busy && n < limit) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic run_sprite(input logic [12:0] c, input logic [3:0] v, input logic [8:0] x,
                            input logic hf, input logic [3:0] p, input bit st, input bit poke);
    stuck_ok = st;
    wait_idle(200);
    push_expected(c, v, x, hf, p);
    code = c; vsub = v; xpos = x; hflip = hf; pal = p; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    chk("busy_rise", 64'(busy), 64'd1);
    if (poke) begin
      repeat ($urandom_range(1, 20)) @(negedge clk);
      if (busy) begin
        code = ~c; vsub = ~v; xpos = x + 9'd7; hflip = ~hf; pal = ~p; draw = 1'b1;
        @(negedge clk);
        draw = 1'b0;
      end
    end
    wait_idle(1000);
    chk("busy_drop", 64'(busy), 64'd0);
    chk("writes_left", 64'(exp_w.size()), 64'd0);
    chk("reqs_left", 64'(exp_a.size()), 64'd0);
    exp_w.delete();
    exp_a.delete();
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst = 1'b1; cen = 1'b0; draw = 1'b0; code = '0; vsub = '0; xpos = '0; hflip = 1'b0;
    pal = '0;
    rom_if.obj_data = '0;
    rom_if.obj_ok = 1'b0;
    fork
      cen_gen();
      rom_model();
      monitor();
    join_none
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_cs", 64'(rom_if.obj_cs), 64'd0);
    chk("rst_addr", 64'(rom_if.obj_addr), 64'd0);
    chk("rst_we", 64'(buf_we), 64'd0);
    chk("rst_baddr", 64'(buf_addr), 64'd0);
    chk("rst_din", 64'(buf_din), 64'd0);
    rst = 1'b0;
    @(negedge clk);

    // Known words at code 0x123 / vsub 5, plain and mirrored
    rom_ovr[18'h0246A] = 32'h8765_4321;
    rom_ovr[18'h0246B] = 32'h0FED_CBA9;
    run_sprite(13'h0123, 4'd5, 9'h010, 1'b0, 4'd3, 1'b0, 1'b0);
    run_sprite(13'h0123, 4'd5, 9'h010, 1'b1, 4'd3, 1'b0, 1'b0);
    // Wrap at the right edge of the buffer
    run_sprite(13'h0123, 4'd5, 9'h1FC, 1'b0, 4'd9, 1'b0, 1'b0);
    // obj_ok stuck high with stale data, plus a draw pulse while busy
    run_sprite(13'h0123, 4'd5, 9'h040, 1'b0, 4'd5, 1'b1, 1'b1);
    run_sprite(13'h1A5C, 4'd2, 9'h080, 1'b1, 4'd6, 1'b1, 1'b1);

    // Reset in the middle of drawing
    stuck_ok = 1'b0;
    push_expected(13'h0123, 4'd5, 9'h020, 1'b0, 4'd7);
    code = 13'h0123; vsub = 4'd5; xpos = 9'h020; hflip = 1'b0; pal = 4'd7; draw = 1'b1;
    @(negedge clk);
    draw = 1'b0;
    n = 0;
    while (!(rom_if.obj_cs === 1'b0 && n > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("first_accept", 64'(rom_if.obj_cs), 64'd0);
    repeat (6) @(negedge clk);
    rst = 1'b1;
    exp_w.delete();
    exp_a.delete();
    @(negedge clk);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    chk("mid_rst_cs", 64'(rom_if.obj_cs), 64'd0);
    chk("mid_rst_we", 64'(buf_we), 64'd0);
    rst = 1'b0;
    @(negedge clk);
    run_sprite(13'h0ABC, 4'd9, 9'h100, 1'b1, 4'd2, 1'b0, 1'b0);

    for (int i = 0; i < 40; i++) begin
      run_sprite(13'($urandom), 4'($urandom), 9'($urandom), 1'($urandom), 4'($urandom),
                 ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
